// File: rtl/free_list.sv
// ---------------------------------------------------------------------------
// free_list
// Circular FIFO of free physical-register tags feeding the rename stage.
// Dispatch pops the head tag, retire pushes the freed T_old at the tail, and
// squash rolls the speculative head back to the committed head in one cycle.
//
// Ports
//   clock        rising-edge clock
//   reset        synchronous, active-high
//   alloc_req    dispatch consumes alloc_tag this cycle
//   alloc_tag    tag at head (show-ahead, combinational from storage)
//   alloc_valid  list non-empty; alloc_tag is meaningful
//   retire_en    oldest ROB entry retires this cycle
//   retire_told  T_old of the retiring instruction, pushed at tail
//   squash       mispredict recovery; head <= commit head
//   free_count   number of free tags, 0..DEPTH
// ---------------------------------------------------------------------------
module free_list #(
    parameter int NUM_PHYS_REGS = 64,
    parameter int NUM_ARCH_REGS = 32,
    parameter int TAG_BITS      = $clog2(NUM_PHYS_REGS),
    parameter int DEPTH         = NUM_PHYS_REGS - NUM_ARCH_REGS
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      alloc_req,
    output logic [TAG_BITS-1:0]       alloc_tag,
    output logic                      alloc_valid,
    input  logic                      retire_en,
    input  logic [TAG_BITS-1:0]       retire_told,
    input  logic                      squash,
    output logic [$clog2(DEPTH):0]    free_count
);
    localparam int IDX = $clog2(DEPTH);
    localparam int PTR = IDX + 1;

    logic [TAG_BITS-1:0] mem_q [DEPTH];
    logic [TAG_BITS-1:0] mem_d [DEPTH];
    logic [PTR-1:0]      head_q, head_d;
    logic [PTR-1:0]      tail_q, tail_d;
    logic [PTR-1:0]      commit_q, commit_d;

    logic empty, full, alloc_fire, push;
    logic [PTR-1:0] inflight;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign empty       = (head_q == tail_q);
    assign full        = (head_q[IDX-1:0] == tail_q[IDX-1:0]) && (head_q[IDX] != tail_q[IDX]);
    assign alloc_valid = !empty;
    assign alloc_tag   = mem_q[head_q[IDX-1:0]];
    assign free_count  = tail_q - head_q;
    assign inflight    = head_q - commit_q;

    // Empty is taken from registered state, so a same-cycle push is never
    // bypassed to a waiting alloc_req.
    assign alloc_fire = alloc_req && !empty && !squash;
    assign push       = retire_en && !full;

    always_comb begin
        mem_d    = mem_q;
        head_d   = head_q;
        tail_d   = tail_q;
        commit_d = commit_q;
        if (push) begin
            mem_d[tail_q[IDX-1:0]] = retire_told;
            tail_d                 = tail_q + PTR'(1);
        end
        if (retire_en)
            commit_d = commit_q + PTR'(1);
        // Squash restores to the commit head including this cycle's retire.
        if (squash)
            head_d = commit_d;
        else if (alloc_fire)
            head_d = head_q + PTR'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= TAG_BITS'(NUM_ARCH_REGS + i);
            head_q   <= '0;
            commit_q <= '0;
            tail_q   <= {1'b1, {IDX{1'b0}}};
        end else begin
            mem_q    <= mem_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            commit_q <= commit_d;
        end
    end

    a_count_bound: assert property (@(posedge clock) disable iff (reset)
        free_count <= PTR'(DEPTH));
    a_inflight_bound: assert property (@(posedge clock) disable iff (reset)
        inflight <= PTR'(DEPTH));
    a_no_retire_past_head: assert property (@(posedge clock) disable iff (reset)
        retire_en |-> (inflight != '0) || (alloc_req && !empty && !squash));
endmodule

// File: tb/tb_free_list.sv
module tb_free_list;
    logic       clock = 1'b0;
    logic       reset;
    logic       alloc_req;
    logic [5:0] alloc_tag;
    logic       alloc_valid;
    logic       retire_en;
    logic [5:0] retire_told;
    logic       squash;
    logic [5:0] free_count;

    free_list dut (
        .clock(clock), .reset(reset),
        .alloc_req(alloc_req), .alloc_tag(alloc_tag), .alloc_valid(alloc_valid),
        .retire_en(retire_en), .retire_told(retire_told),
        .squash(squash), .free_count(free_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit     valid;
        int     tag;
        int     count;
        string  name;
    } exp_t;

    exp_t exp_q[$];
    int   free_q[$];   // free tags, front = next to allocate
    int   spec_q[$];   // allocated but not yet retired, oldest first
    int   n_cmp = 0;
    int   n_err = 0;
    bit   done  = 0;

    function automatic void push_exp(string name);
        exp_t e;
        e.valid = free_q.size() > 0;
        e.tag   = e.valid ? free_q[0] : 0;
        e.count = free_q.size();
        e.name  = name;
        exp_q.push_back(e);
    endfunction

    // One clock of stimulus; the model applies the same cycle's rules as
    // list operations and queues the expected post-edge view.
    task automatic cycle(input bit areq, input bit ren, input int told,
                         input bit sq, input string name);
        bit grant;
        @(negedge clock);
        reset = 0; alloc_req = areq; retire_en = ren;
        retire_told = 6'(told); squash = sq;
        @(posedge clock);
        grant = areq && (free_q.size() > 0) && !sq;
        if (grant) spec_q.push_back(free_q.pop_front());
        if (ren) begin
            if (spec_q.size() > 0) void'(spec_q.pop_front());
            if (free_q.size() < 32) free_q.push_back(told);
        end
        if (sq) begin
            while (spec_q.size() > 0) free_q.push_front(spec_q.pop_back());
        end
        push_exp(name);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1; alloc_req = 0; retire_en = 0; retire_told = 0; squash = 0;
        @(posedge clock);
        free_q.delete(); spec_q.delete();
        for (int i = 32; i < 64; i++) free_q.push_back(i);
        push_exp("reset");
        @(negedge clock);
        reset = 0;
    endtask

    // Monitor: compares every queued expectation against the DUT just after the edge.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            while (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                n_cmp++;
                if (alloc_valid !== e.valid || int'(free_count) !== e.count ||
                    (e.valid && int'(alloc_tag) !== e.tag)) begin
                    n_err++;
                    $display("FAIL %s: got valid=%0d tag=%0d count=%0d, want valid=%0d tag=%0d count=%0d",
                             e.name, alloc_valid, alloc_tag, free_count, e.valid, e.tag, e.count);
                end
            end
        end
    end

    initial begin
        reset = 1; alloc_req = 0; retire_en = 0; retire_told = 0; squash = 0;

        // 1: reset state
        do_reset();
        // 2: drain 32 tags in order, then one alloc while empty
        for (int i = 0; i < 32; i++) cycle(1, 0, 0, 0, "drain");
        cycle(1, 0, 0, 0, "alloc_empty");
        // 3: push into empty list with same-cycle alloc (not granted)
        cycle(1, 1, 5, 0, "push_empty");
        // 4: bring count to 10, then alloc+retire keeps it steady
        for (int i = 0; i < 9; i++) cycle(0, 1, 10 + i, 0, "fill10");
        for (int i = 0; i < 4; i++) cycle(1, 1, 9, 0, "alloc_retire");
        // 5: squash after partial alloc and a retire
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, "alloc3");
        cycle(0, 1, 7, 0, "retire7");
        cycle(0, 0, 0, 1, "squash");
        for (int i = 0; i < 32; i++) cycle(1, 0, 0, 0, "post_squash_order");
        // 6: tail wrap with tags 0..31
        do_reset();
        for (int i = 0; i < 32; i++) cycle(1, 0, 0, 0, "alloc32");
        for (int i = 0; i < 32; i++) cycle(0, 1, i, 0, "retire_wrap");
        for (int i = 0; i < 32; i++) cycle(1, 0, 0, 0, "realloc_wrap");
        // Random traffic obeying the driver rules (retire only with in-flight work)
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            bit a, r, s;
            a = ($urandom_range(0, 3) != 0);
            r = (spec_q.size() > 0) && ($urandom_range(0, 2) == 0);
            s = ($urandom_range(0, 31) == 0);
            cycle(a, r, $urandom_range(0, 63), s, "random");
            if ($urandom_range(0, 999) == 0) do_reset();
        end
        // Squash with same-cycle retire and alloc
        cycle(1, 0, 0, 0, "pre_sq");
        cycle(1, 0, 0, 0, "pre_sq");
        cycle(1, 1, 44, 1, "squash_retire");

        @(negedge clock);
        alloc_req = 0; retire_en = 0; squash = 0;
        repeat (3) @(posedge clock);
        #2;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_exp: got %0d pending, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        done = 1;
        $finish;
    end

    initial begin
        #2000000;
        if (!done) begin
            $display("FAIL timeout: got no completion, want finish");
            $fatal(1, "timeout");
        end
    end
endmodule
